// File: rtl/ps2_mouse_rx_pkg.sv
// Shared types, byte-0 field positions and sign/magnitude helper for the PS/2 mouse receiver.
package ps2_mouse_rx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } frame_state_e;

    localparam int unsigned B0_L    = 0;
    localparam int unsigned B0_R    = 1;
    localparam int unsigned B0_M    = 2;
    localparam int unsigned B0_SYNC = 3;
    localparam int unsigned B0_XS   = 4;
    localparam int unsigned B0_YS   = 5;
    localparam int unsigned B0_XO   = 6;
    localparam int unsigned B0_YO   = 7;

    localparam int unsigned DEF_FILTER_LEN = 4;

    typedef struct packed {
        logic       neg;
        logic [7:0] mag;
    } sign_mag_t;

    // 9-bit two's complement to sign+magnitude; -256 has no 8-bit magnitude so it clips to 255.
    function automatic sign_mag_t to_sign_mag(input logic [8:0] v);
        sign_mag_t  r;
        logic [8:0] n;
        n     = v[8] ? (~v + 9'd1) : v;
        r.neg = v[8];
        r.mag = n[8] ? 8'hFF : n[7:0];
        return r;
    endfunction

endpackage

// File: rtl/ps2_mouse_rx_if.sv
// Decoded mouse packet bus from the PS/2 receiver to the game engine.
interface ps2_mouse_rx_if;
    logic [7:0] mouse_x;
    logic       is_mouse_x_neg;
    logic [7:0] mouse_y;
    logic       is_mouse_y_neg;
    logic [2:0] o_buttons;
    logic       o_packet_valid;
    logic [7:0] o_err_cnt;

    modport master (
        output mouse_x,
        output is_mouse_x_neg,
        output mouse_y,
        output is_mouse_y_neg,
        output o_buttons,
        output o_packet_valid,
        output o_err_cnt
    );

    modport slave (
        input mouse_x,
        input is_mouse_x_neg,
        input mouse_y,
        input is_mouse_y_neg,
        input o_buttons,
        input o_packet_valid,
        input o_err_cnt
    );
endinterface

// File: rtl/ps2_mouse_rx_line_filter.sv
// Two-flop synchroniser plus N-sample glitch filter for one raw PS/2 pin.
module ps2_line_filter
    import ps2_mouse_rx_pkg::*;
#(
    parameter int unsigned FILTER_LEN = DEF_FILTER_LEN
) (
    input  logic clk,
    input  logic arst_n,
    input  logic line_i,
    output logic level_o,
    output logic fall_o
);

    logic [1:0]            sync_q;
    logic [FILTER_LEN-1:0] hist_q;
    logic [FILTER_LEN-1:0] hist_d;
    logic                  level_q;
    logic                  level_d;
    logic                  fall_q;
    logic                  fall_d;

    // Level only moves once the whole history window agrees.
    always_comb begin
        hist_d  = {hist_q[FILTER_LEN-2:0], sync_q[1]};
        level_d = level_q;
        if (&hist_q) begin
            level_d = 1'b1;
        end else if (~|hist_q) begin
            level_d = 1'b0;
        end
        fall_d = level_q & ~level_d;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sync_q  <= 2'b11;
            hist_q  <= '1;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], line_i};
            hist_q  <= hist_d;
            level_q <= level_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_mouse_rx.sv
// Receive-only PS/2 mouse front end: frame deserialiser, 3-byte packet assembler, sign+magnitude output pulse.
module ps2_mouse_rx
    import ps2_mouse_rx_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter bit          INVERT_Y       = 1'b1
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  i_ps2_clk,
    input  logic                  i_ps2_data,
    ps2_mouse_rx_if.master        mouse_o
);

    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic clk_level;
    logic clk_fall;
    logic data_level;
    logic data_fall;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk     (clk),
        .arst_n  (arst_n),
        .line_i  (i_ps2_clk),
        .level_o (clk_level),
        .fall_o  (clk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk     (clk),
        .arst_n  (arst_n),
        .line_i  (i_ps2_data),
        .level_o (data_level),
        .fall_o  (data_fall)
    );

    frame_state_e     state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             parity_q, parity_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic [7:0]       b0_q, b0_d;
    logic [7:0]       b1_q, b1_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             err_inc;
    logic             commit;
    logic             active;

    logic             valid_q;
    logic [7:0]       mouse_x_q, mouse_x_d;
    logic             x_neg_q, x_neg_d;
    logic [7:0]       mouse_y_q, mouse_y_d;
    logic             y_neg_q, y_neg_d;
    logic [2:0]       buttons_q;
    logic [7:0]       err_cnt_q;

    sign_mag_t        x_sm;
    sign_mag_t        y_sm;

    // Clock level, data edges and the always-set sync bit carry no extra information here.
    logic unused_lines;
    assign unused_lines = ^{clk_level, data_fall, b0_q[B0_SYNC]};

    assign active = (state_q != IDLE) || (byte_idx_q != 2'd0);

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        byte_idx_d = byte_idx_q;
        b0_d       = b0_q;
        b1_d       = b1_q;
        tmo_cnt_d  = tmo_cnt_q;
        err_inc    = 1'b0;
        commit     = 1'b0;

        if (clk_fall) begin
            // A falling edge always beats a coincident timeout.
            tmo_cnt_d = '0;
            case (state_q)
                IDLE: begin
                    if (!data_level) begin
                        state_d   = DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                DATA: begin
                    shift_d   = {data_level, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    parity_d = data_level;
                    state_d  = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (data_level && (^{shift_q, parity_q})) begin
                        case (byte_idx_q)
                            2'd0: begin
                                if (shift_q[B0_SYNC]) begin
                                    b0_d       = shift_q;
                                    byte_idx_d = 2'd1;
                                end else begin
                                    err_inc = 1'b1;
                                end
                            end
                            2'd1: begin
                                b1_d       = shift_q;
                                byte_idx_d = 2'd2;
                            end
                            default: begin
                                commit     = 1'b1;
                                byte_idx_d = 2'd0;
                            end
                        endcase
                    end else begin
                        err_inc    = 1'b1;
                        byte_idx_d = 2'd0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (active) begin
            if (tmo_cnt_q == TMO_LAST) begin
                tmo_cnt_d  = '0;
                state_d    = IDLE;
                byte_idx_d = 2'd0;
                err_inc    = (state_q != IDLE);
            end else begin
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            end
        end else begin
            tmo_cnt_d = '0;
        end
    end

    // Decode uses the byte still sitting in shift_q as byte 2 during the commit cycle.
    always_comb begin
        x_sm = to_sign_mag({b0_q[B0_XS], b1_q});
        if (b0_q[B0_XO]) begin
            x_sm.neg = b0_q[B0_XS];
            x_sm.mag = 8'hFF;
        end

        y_sm = to_sign_mag({b0_q[B0_YS], shift_q});
        if (b0_q[B0_YO]) begin
            y_sm.neg = b0_q[B0_YS];
            y_sm.mag = 8'hFF;
        end
        if (INVERT_Y) begin
            y_sm.neg = ~y_sm.neg;
        end

        mouse_x_d = commit ? x_sm.mag : 8'd0;
        x_neg_d   = commit & x_sm.neg & (|x_sm.mag);
        mouse_y_d = commit ? y_sm.mag : 8'd0;
        y_neg_d   = commit & y_sm.neg & (|y_sm.mag);
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'd0;
            parity_q   <= 1'b0;
            byte_idx_q <= 2'd0;
            b0_q       <= 8'd0;
            b1_q       <= 8'd0;
            tmo_cnt_q  <= '0;
            valid_q    <= 1'b0;
            mouse_x_q  <= 8'd0;
            x_neg_q    <= 1'b0;
            mouse_y_q  <= 8'd0;
            y_neg_q    <= 1'b0;
            buttons_q  <= 3'd0;
            err_cnt_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            byte_idx_q <= byte_idx_d;
            b0_q       <= b0_d;
            b1_q       <= b1_d;
            tmo_cnt_q  <= tmo_cnt_d;
            valid_q    <= commit;
            mouse_x_q  <= mouse_x_d;
            x_neg_q    <= x_neg_d;
            mouse_y_q  <= mouse_y_d;
            y_neg_q    <= y_neg_d;
            if (commit) begin
                buttons_q <= {b0_q[B0_M], b0_q[B0_R], b0_q[B0_L]};
            end
            if (err_inc && (err_cnt_q != 8'hFF)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    assign mouse_o.mouse_x        = mouse_x_q;
    assign mouse_o.is_mouse_x_neg = x_neg_q;
    assign mouse_o.mouse_y        = mouse_y_q;
    assign mouse_o.is_mouse_y_neg = y_neg_q;
    assign mouse_o.o_buttons      = buttons_q;
    assign mouse_o.o_packet_valid = valid_q;
    assign mouse_o.o_err_cnt      = err_cnt_q;

endmodule
